// File: rtl/ldtu_pkg.sv
// Shared LiTe-DTU definitions: default widths and Hamming layout helpers
// used by the SECDED encoder now and the decoder later.
`timescale 1ns/1ps
package ldtu_pkg;

    localparam int LDTU_DATA_W    = 32;
    localparam int LDTU_HAM_PAR_W = 6;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int ham_par_bits(input int data_w);
        int p;
        p = 0;
        for (int q = 8; q >= 1; q--)
            if ((1 << q) >= data_w + q + 1) p = q;
        return p;
    endfunction

    // Codeword index i holds a parity bit when i+1 is a power of two.
    function automatic logic ham_is_par_pos(input int i);
        return ((i + 1) & i) == 0;
    endfunction

endpackage

// File: rtl/ldtu_hamm_secded_core.sv
// Combinational Hamming/SECDED mapping: scatter data bits, generate parity,
// and optionally append overall even parity at the MSB.
`timescale 1ns/1ps
module ldtu_hamm_secded_core
    import ldtu_pkg::*;
#(
    parameter int DATA_W = LDTU_DATA_W,
    parameter int PAR_W  = LDTU_HAM_PAR_W,
    parameter int SECDED = 1
) (
    input  logic [DATA_W-1:0]              data,
    output logic [DATA_W+PAR_W+SECDED-1:0] code
);

    localparam int HW = DATA_W + PAR_W;

    // Data positions covered by parity bit k: (i+1) has bit k set.
    function automatic logic [HW-1:0] cover_mask(input int k);
        logic [HW-1:0] m;
        m = '0;
        for (int i = 0; i < HW; i++)
            m[i] = !ham_is_par_pos(i) && ((((i + 1) >> k) & 1) != 0);
        return m;
    endfunction

    logic [HW-1:0]    dpos;
    logic [HW-1:0]    hamm;
    logic [PAR_W-1:0] par;

    // Number of parity slots below a data position i is $clog2(i+1).
    for (genvar i = 0; i < HW; i++) begin : g_pos
        if (ham_is_par_pos(i)) begin : g_par
            assign dpos[i] = 1'b0;
            assign hamm[i] = par[$clog2(i + 1)];
        end else begin : g_dat
            assign dpos[i] = data[i - $clog2(i + 1)];
            assign hamm[i] = dpos[i];
        end
    end

    for (genvar k = 0; k < PAR_W; k++) begin : g_parity
        localparam logic [HW-1:0] MASK = cover_mask(k);
        assign par[k] = ^(dpos & MASK);
    end

    if (SECDED != 0) begin : g_secded
        assign code = {^hamm, hamm};
    end else begin : g_plain
        assign code = hamm;
    end

endmodule

// File: rtl/ldtu_hamm_secded_enc.sv
// LiTe-DTU Hamming/SECDED encoder: valid/ready registered output with a
// one-entry skid buffer, one-shot error injection and a wrapping word counter.
`timescale 1ns/1ps
module ldtu_hamm_secded_enc
    import ldtu_pkg::*;
#(
    parameter int DATA_W = LDTU_DATA_W,
    parameter int PAR_W  = LDTU_HAM_PAR_W,
    parameter int SECDED = 1,
    parameter int CNT_W  = 16
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_W+PAR_W+SECDED-1:0] out_code,
    output logic                           out_valid,
    input  logic                           out_ready,
    input  logic                           inj_req,
    input  logic [DATA_W+PAR_W+SECDED-1:0] inj_mask,
    output logic                           inj_armed,
    output logic                           inj_done,
    output logic [CNT_W-1:0]               word_cnt
);

    localparam int CW = DATA_W + PAR_W + SECDED;

    if (DATA_W < 4 || DATA_W > 57) begin : g_bad_data_w
        $error("ldtu_hamm_secded_enc: DATA_W %0d outside 4..57", DATA_W);
    end
    if (PAR_W != ham_par_bits(DATA_W)) begin : g_bad_par_w
        $error("ldtu_hamm_secded_enc: PAR_W %0d, need %0d", PAR_W, ham_par_bits(DATA_W));
    end

    logic [CW-1:0] enc_code;
    logic [CW-1:0] in_code;
    logic [CW-1:0] skid_code;
    logic [CW-1:0] inj_mask_q;
    logic          skid_full;
    logic          accept;
    logic          out_free;

    ldtu_hamm_secded_core #(
        .DATA_W (DATA_W),
        .PAR_W  (PAR_W),
        .SECDED (SECDED)
    ) u_core (
        .data (in_data),
        .code (enc_code)
    );

    assign in_ready = !skid_full;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    // Injection lands after overall parity so the decoder sees a real error.
    assign in_code  = enc_code ^ (inj_armed ? inj_mask_q : '0);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            out_code   <= '0;
            out_valid  <= 1'b0;
            skid_code  <= '0;
            skid_full  <= 1'b0;
            inj_armed  <= 1'b0;
            inj_mask_q <= '0;
            inj_done   <= 1'b0;
            word_cnt   <= '0;
        end else begin
            if (out_free) begin
                if (skid_full) begin
                    out_code  <= skid_code;
                    out_valid <= 1'b1;
                    skid_full <= accept;
                    if (accept) skid_code <= in_code;
                end else if (accept) begin
                    out_code  <= in_code;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_code <= in_code;
                skid_full <= 1'b1;
            end

            inj_done <= accept && inj_armed;
            if (accept && inj_armed) begin
                inj_armed <= 1'b0;
            end else if (inj_req && !inj_armed) begin
                inj_armed  <= 1'b1;
                inj_mask_q <= inj_mask;
            end

            word_cnt <= word_cnt + CNT_W'(accept);
        end
    end

endmodule

// File: tb/tb_ldtu_hamm_secded_enc.sv
// Scoreboarded bench for the LiTe-DTU SECDED encoder: default 32/6/SECDED,
// a CNT_W=4 instance for wrap, and an 8/4 plain-Hamming instance.
`timescale 1ns/1ps
module tb_ldtu_hamm_secded_enc;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    always #5 CLK = ~CLK;

    // default instance
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [38:0] out_code, inj_mask = '0;
    logic        inj_req = 1'b0, inj_armed, inj_done;
    logic [15:0] word_cnt;

    // counter-wrap instance
    logic [31:0] in_data_w = '0;
    logic        in_valid_w = 1'b0, in_ready_w, out_valid_w;
    logic [38:0] out_code_w;
    logic        inj_armed_w, inj_done_w;
    logic [3:0]  word_cnt_w;

    // small plain-Hamming instance
    logic [7:0]  in_data_s = '0;
    logic        in_valid_s = 1'b0, in_ready_s, out_valid_s;
    logic [11:0] out_code_s;
    logic        inj_armed_s, inj_done_s;
    logic [15:0] word_cnt_s;

    int checks = 0;
    int errors = 0;
    logic [38:0] q[$];

    ldtu_hamm_secded_enc dut (
        .CLK(CLK), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_code(out_code), .out_valid(out_valid),
        .out_ready(out_ready), .inj_req(inj_req), .inj_mask(inj_mask),
        .inj_armed(inj_armed), .inj_done(inj_done), .word_cnt(word_cnt));

    ldtu_hamm_secded_enc #(.CNT_W(4)) dut_w (
        .CLK(CLK), .reset(reset), .in_data(in_data_w), .in_valid(in_valid_w),
        .in_ready(in_ready_w), .out_code(out_code_w), .out_valid(out_valid_w),
        .out_ready(1'b1), .inj_req(1'b0), .inj_mask(39'h0),
        .inj_armed(inj_armed_w), .inj_done(inj_done_w), .word_cnt(word_cnt_w));

    ldtu_hamm_secded_enc #(.DATA_W(8), .PAR_W(4), .SECDED(0)) dut_s (
        .CLK(CLK), .reset(reset), .in_data(in_data_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .out_code(out_code_s), .out_valid(out_valid_s),
        .out_ready(1'b1), .inj_req(1'b0), .inj_mask(12'h0),
        .inj_armed(inj_armed_s), .inj_done(inj_done_s), .word_cnt(word_cnt_s));

    // Reference: syndrome view -- parity vector is the XOR of the 1-based
    // positions of all set data bits.
    function automatic logic [63:0] ref_enc(input logic [63:0] d, input int dw,
                                            input int pw, input int sd);
        logic [63:0] cw;
        int syn, j;
        cw = '0; syn = 0; j = 0;
        for (int pos = 1; pos <= dw + pw; pos++)
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                if (d[j]) syn = syn ^ pos;
                j++;
            end
        for (int k = 0; k < pw; k++) cw[(1 << k) - 1] = syn[k];
        if (sd != 0) cw[dw+pw] = ^cw;
        return cw;
    endfunction

    function automatic int syndrome12(input logic [11:0] c);
        int s;
        s = 0;
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        return s;
    endfunction

    function automatic logic [38:0] ref32(input logic [31:0] d);
        logic [63:0] r;
        r = ref_enc({32'h0, d}, 32, 6, 1);
        return r[38:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge CLK) begin
        if (reset && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got %h want none", out_code);
            end else begin
                logic [38:0] exp;
                exp = q.pop_front();
                if (out_code !== exp) begin
                    errors++;
                    $display("FAIL scoreboard got %h want %h", out_code, exp);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [38:0] exp);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1; q.push_back(exp);
        while (!in_ready && n < 50) begin @(posedge CLK); #1; n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=0 want 1");
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge CLK); #1; n++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d left want 0", q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b1;
    endtask

    task automatic pulse_inj(input logic [38:0] m);
        inj_req = 1'b1; inj_mask = m;
        @(posedge CLK); #1;
        inj_req = 1'b0;
    endtask

    initial begin
        logic [11:0] c;
        logic [63:0] r;

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_inj_armed", inj_armed, 0);
        chk("rst_inj_done", inj_done, 0);

        // Directed vectors, 1-cycle latency.
        send(32'h0000_0001, 39'h40_0000_0007);
        chk("latency_valid", out_valid, 1);
        send(32'hFFFF_FFFF, 39'h3F_7FFF_FFF4);
        send(32'h0000_0000, 39'h00_0000_0000);
        drain();

        // Back-pressure: output + skid hold two words, then stall.
        do_reset();
        send(32'hA0, ref32(32'hA0));
        out_ready = 1'b0;
        send(32'hA1, ref32(32'hA1));
        chk("bp_in_ready_low", in_ready, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_code", out_code, ref32(32'hA0));
        chk("bp_still_full", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 2; i < 6; i++) send(32'hA0 + i, ref32(32'hA0 + i));
        drain();
        chk("bp_word_cnt", word_cnt, 6);

        // Injection: one-shot flip of bit 0, overall parity untouched.
        pulse_inj(39'h1);
        chk("inj_armed_set", inj_armed, 1);
        send(32'h0000_0001, 39'h40_0000_0006);
        chk("inj_done_pulse", inj_done, 1);
        chk("inj_armed_clr", inj_armed, 0);
        send(32'h0000_0001, 39'h40_0000_0007);
        chk("inj_done_once", inj_done, 0);

        // Second request while armed is ignored.
        pulse_inj(39'h1);
        pulse_inj(39'h2);
        send(32'h0, 39'h1);
        // Request coincident with an accept arms for the next word.
        inj_req = 1'b1; inj_mask = 39'h4;
        send(32'h0, 39'h0);
        inj_req = 1'b0;
        chk("inj_same_cycle_armed", inj_armed, 1);
        send(32'h0, 39'h4);
        drain();

        // Mid-stream reset with skid full and injection armed.
        out_ready = 1'b0;
        send(32'hB0, ref32(32'hB0));
        send(32'hB1, ref32(32'hB1));
        pulse_inj(39'h8);
        chk("mid_skid_full", in_ready, 0);
        reset = 1'b0;
        @(posedge CLK); #1;
        q.delete();
        chk("mid_out_valid", out_valid, 0);
        chk("mid_word_cnt", word_cnt, 0);
        chk("mid_inj_armed", inj_armed, 0);
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid_rel", out_valid, 0);
        out_ready = 1'b1;
        send(32'hC0, ref32(32'hC0));
        drain();

        // Counter wrap, 4-bit counter, 17 back-to-back accepts.
        in_valid_w = 1'b1;
        repeat (17) @(posedge CLK);
        #1 in_valid_w = 1'b0;
        chk("wrap_word_cnt", word_cnt_w, 1);

        // Plain Hamming 8/4: all values, streaming, every single-bit flip.
        in_valid_s = 1'b1;
        for (int v = 0; v < 256; v++) begin
            in_data_s = 8'(v);
            @(posedge CLK); #1;
            c = out_code_s;
            r = ref_enc(64'(v), 8, 4, 0);
            chk("s_valid", out_valid_s, 1);
            chk("s_code", c, r[11:0]);
            for (int b = 0; b < 12; b++)
                chk("s_flip_syndrome", syndrome12(c ^ (12'h1 << b)), b + 1);
        end
        in_valid_s = 1'b0;

        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
